// File: rtl/expr_exec_pkg.sv
// expr_exec_pkg: opcode, error and FSM encodings shared by the expression executor.
// Defining EXPR_EXEC_DIV_EN adds the divider wait state to state_e.
package expr_exec_pkg;

  typedef enum logic [3:0] {
    NK_NUM    = 4'd0,
    NK_ADDR   = 4'd1,
    NK_LOAD   = 4'd2,
    NK_ASSIGN = 4'd3,
    NK_ADD    = 4'd4,
    NK_SUB    = 4'd5,
    NK_MUL    = 4'd6,
    NK_DIV    = 4'd7,
    NK_EQ     = 4'd8,
    NK_NE     = 4'd9,
    NK_GT     = 4'd10,
    NK_GE     = 4'd11,
    NK_POP    = 4'd12,
    NK_RET    = 4'd13
  } node_kind_e;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_UNDERFLOW = 3'd1,
    ERR_OVERFLOW  = 3'd2,
    ERR_DIV_ZERO  = 3'd3,
    ERR_ILLEGAL   = 3'd4
  } err_code_e;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_HALT     = 2'd1
`ifdef EXPR_EXEC_DIV_EN
    , ST_DIV_WAIT = 2'd2
`endif
  } state_e;

endpackage

// File: rtl/expr_exec_if.sv
// expr_exec_if: node stream handshake plus result/fault reporting bundle.
// master drives nodes (upstream codegen), slave is the executor.
interface expr_exec_if #(
  parameter int DATA_W = 32,
  parameter int OFF_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_kind;
  logic [DATA_W-1:0] in_imm;
  logic [OFF_W-1:0]  in_off;
  logic              ret_valid;
  logic [DATA_W-1:0] ret_value;
  logic              err_valid;
  logic [2:0]        err_code;
  logic              busy;

  modport master (
    output in_valid, in_kind, in_imm, in_off,
    input  in_ready, ret_valid, ret_value, err_valid, err_code, busy
  );

  modport slave (
    input  in_valid, in_kind, in_imm, in_off,
    output in_ready, ret_valid, ret_value, err_valid, err_code, busy
  );
endinterface

// File: rtl/expr_exec_div.sv
// expr_exec_div: iterative signed restoring divider, one quotient bit per cycle.
// Operands are captured on start_i; done_o is high for the single cycle after
// DATA_W iterations, so start-to-consume spans DATA_W+1 clock edges.
// Quotient truncates toward zero; MIN / -1 wraps back to MIN.
module expr_exec_div #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic              done_o,
  output logic [DATA_W-1:0] quotient_o
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic              active_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] dvs_q;
  logic              neg_q;
  logic [DATA_W:0]   rem_sh;
  logic [DATA_W:0]   diff;

  // Trial subtraction of the magnitude divisor from the shifted remainder.
  always_comb begin
    rem_sh = {rem_q, quo_q[DATA_W-1]};
    diff   = rem_sh - {1'b0, dvs_q};
  end

  // Operand capture on start, then one restoring step per cycle until done.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      neg_q    <= 1'b0;
    end else if (start_i) begin
      active_q <= 1'b1;
      cnt_q    <= '0;
      quo_q    <= dividend_i[DATA_W-1] ? -dividend_i : dividend_i;
      dvs_q    <= divisor_i[DATA_W-1] ? -divisor_i : divisor_i;
      rem_q    <= '0;
      neg_q    <= dividend_i[DATA_W-1] ^ divisor_i[DATA_W-1];
    end else if (active_q) begin
      if (cnt_q == CNT_W'(DATA_W)) begin
        active_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
        quo_q <= {quo_q[DATA_W-2:0], ~diff[DATA_W]};
        rem_q <= diff[DATA_W] ? rem_sh[DATA_W-1:0] : diff[DATA_W-1:0];
      end
    end
  end

  assign done_o     = active_q && (cnt_q == CNT_W'(DATA_W));
  assign quotient_o = neg_q ? -quo_q : quo_q;
endmodule

// File: rtl/expr_exec_ctrl.sv
// expr_exec_ctrl: executes a postorder expression node stream on an evaluation
// stack and a local-variable frame, reporting the RET value or the first fault.
// EXPR_EXEC_DIV_EN: instantiate the divider; otherwise DIV is an illegal kind.
module expr_exec_ctrl
  import expr_exec_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int STACK_DEPTH = 16,
  parameter int NUM_LVARS   = 32
) (
  input logic        clk,
  input logic        rst,
  expr_exec_if.slave node_if
);
  localparam int OFF_W  = $clog2(NUM_LVARS) + 3;
  localparam int SP_W   = $clog2(STACK_DEPTH) + 1;
  localparam int IDX_W  = $clog2(STACK_DEPTH);
  localparam int SLOT_W = $clog2(NUM_LVARS);

  state_e            state_q, state_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [DATA_W-1:0] stack_q [STACK_DEPTH];
  logic [DATA_W-1:0] frame_q [NUM_LVARS];
  logic              ret_valid_q, ret_valid_d;
  logic [DATA_W-1:0] ret_value_q, ret_value_d;
  logic              err_valid_q, err_valid_d;
  err_code_e         err_code_q, err_code_d;

  logic [IDX_W-1:0]  top_idx, sec_idx, st_idx;
  logic [DATA_W-1:0] top_val, sec_val, st_val, alu_val, fr_val;
  logic [SLOT_W-1:0] fr_idx;
  logic              st_we, fr_we, has1, has2, full;
  err_code_e         fault;

  function automatic logic addr_ok(input logic [DATA_W-1:0] a);
    return (a[2:0] == 3'b000) && (a[DATA_W-1:OFF_W] == '0);
  endfunction

  function automatic logic [SLOT_W-1:0] slot_of(input logic [DATA_W-1:0] a);
    return a[OFF_W-1:3];
  endfunction

  assign top_idx = IDX_W'(sp_q - SP_W'(1));
  assign sec_idx = IDX_W'(sp_q - SP_W'(2));
  assign top_val = stack_q[top_idx];
  assign sec_val = stack_q[sec_idx];
  assign has1    = (sp_q != '0);
  assign has2    = (sp_q >= SP_W'(2));
  assign full    = (sp_q == SP_W'(STACK_DEPTH));

`ifdef EXPR_EXEC_DIV_EN
  logic              div_start;
  logic              div_done;
  logic [DATA_W-1:0] div_quot;

  expr_exec_div #(.DATA_W(DATA_W)) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_start),
    .dividend_i (sec_val),
    .divisor_i  (top_val),
    .done_o     (div_done),
    .quotient_o (div_quot)
  );
`endif

  // Binary operator result with a = second-from-top, b = top.
  always_comb begin
    alu_val = sec_val + top_val;
    case (node_if.in_kind)
      NK_SUB:  alu_val = sec_val - top_val;
      NK_MUL:  alu_val = sec_val * top_val;
      NK_EQ:   alu_val = DATA_W'(sec_val == top_val);
      NK_NE:   alu_val = DATA_W'(sec_val != top_val);
      NK_GT:   alu_val = DATA_W'($signed(sec_val) > $signed(top_val));
      NK_GE:   alu_val = DATA_W'($signed(sec_val) >= $signed(top_val));
      default: alu_val = sec_val + top_val;
    endcase
  end

  // Node decode, fault detection and next state; a fault cancels all updates.
  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    st_we       = 1'b0;
    st_idx      = top_idx;
    st_val      = top_val;
    fr_we       = 1'b0;
    fr_idx      = slot_of(top_val);
    fr_val      = top_val;
    ret_valid_d = ret_valid_q;
    ret_value_d = ret_value_q;
    err_valid_d = err_valid_q;
    err_code_d  = err_code_q;
    fault       = ERR_NONE;
`ifdef EXPR_EXEC_DIV_EN
    div_start   = 1'b0;
`endif
    if (state_q == ST_RUN && node_if.in_valid) begin
      case (node_if.in_kind)
        NK_NUM, NK_ADDR: begin
          if (full) fault = ERR_OVERFLOW;
          else begin
            st_we  = 1'b1;
            st_idx = IDX_W'(sp_q);
            st_val = (node_if.in_kind == NK_NUM) ? node_if.in_imm : DATA_W'(node_if.in_off);
            sp_d   = sp_q + SP_W'(1);
          end
        end
        NK_LOAD: begin
          if (!has1) fault = ERR_UNDERFLOW;
          else if (!addr_ok(top_val)) fault = ERR_ILLEGAL;
          else begin
            st_we  = 1'b1;
            st_val = frame_q[slot_of(top_val)];
          end
        end
        NK_ASSIGN: begin
          if (!has2) fault = ERR_UNDERFLOW;
          else if (!addr_ok(sec_val)) fault = ERR_ILLEGAL;
          else begin
            fr_we  = 1'b1;
            fr_idx = slot_of(sec_val);
            st_we  = 1'b1;
            st_idx = sec_idx;
            sp_d   = sp_q - SP_W'(1);
          end
        end
        NK_ADD, NK_SUB, NK_MUL, NK_EQ, NK_NE, NK_GT, NK_GE: begin
          if (!has2) fault = ERR_UNDERFLOW;
          else begin
            st_we  = 1'b1;
            st_idx = sec_idx;
            st_val = alu_val;
            sp_d   = sp_q - SP_W'(1);
          end
        end
`ifdef EXPR_EXEC_DIV_EN
        NK_DIV: begin
          if (!has2) fault = ERR_UNDERFLOW;
          else if (top_val == '0) fault = ERR_DIV_ZERO;
          else begin
            div_start = 1'b1;
            state_d   = ST_DIV_WAIT;
          end
        end
`else
        NK_DIV: fault = ERR_ILLEGAL;
`endif
        NK_POP: begin
          if (!has1) fault = ERR_UNDERFLOW;
          else sp_d = sp_q - SP_W'(1);
        end
        NK_RET: begin
          if (!has1) fault = ERR_UNDERFLOW;
          else begin
            ret_valid_d = 1'b1;
            ret_value_d = top_val;
            sp_d        = sp_q - SP_W'(1);
            state_d     = ST_HALT;
          end
        end
        default: fault = ERR_ILLEGAL;
      endcase
      if (fault != ERR_NONE) begin
        st_we       = 1'b0;
        fr_we       = 1'b0;
        sp_d        = sp_q;
        err_valid_d = 1'b1;
        err_code_d  = fault;
        state_d     = ST_HALT;
      end
    end
`ifdef EXPR_EXEC_DIV_EN
    else if (state_q == ST_DIV_WAIT && div_done) begin
      st_we   = 1'b1;
      st_idx  = sec_idx;
      st_val  = div_quot;
      sp_d    = sp_q - SP_W'(1);
      state_d = ST_RUN;
    end
`endif
  end

  // State, stack, frame and result registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      sp_q        <= '0;
      ret_valid_q <= 1'b0;
      ret_value_q <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
      for (int i = 0; i < NUM_LVARS; i++) frame_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      ret_valid_q <= ret_valid_d;
      ret_value_q <= ret_value_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      if (st_we) stack_q[st_idx] <= st_val;
      if (fr_we) frame_q[fr_idx] <= fr_val;
    end
  end

  assign node_if.in_ready  = (state_q == ST_RUN);
  assign node_if.ret_valid = ret_valid_q;
  assign node_if.ret_value = ret_value_q;
  assign node_if.err_valid = err_valid_q;
  assign node_if.err_code  = err_code_q;
`ifdef EXPR_EXEC_DIV_EN
  assign node_if.busy      = (state_q == ST_DIV_WAIT);
`else
  assign node_if.busy      = 1'b0;
`endif
endmodule

// File: tb/tb_expr_exec_ctrl.sv
// tb_expr_exec_ctrl: directed self-checking bench for expr_exec_ctrl.
// Honours EXPR_EXEC_DIV_EN to select the expected DIV behaviour.
module tb_expr_exec_ctrl;
  import expr_exec_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

`ifdef EXPR_EXEC_DIV_EN
  localparam logic [2:0] DIV0_CODE = 3'd3;
`else
  localparam logic [2:0] DIV0_CODE = 3'd4;
`endif

  expr_exec_if bus ();

  expr_exec_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .node_if (bus)
  );

  // Free-running clock, rising edge active.
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_kind  = NK_POP;
    bus.in_imm   = '0;
    bus.in_off   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Present one node and hold it until accepted; returns 1 time unit after the accepting edge.
  task automatic send(input logic [3:0] kind, input logic [31:0] imm, input logic [7:0] off);
    int guard;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_kind  = kind;
    bus.in_imm   = imm;
    bus.in_off   = off;
    while (bus.in_ready !== 1'b1 && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 100) begin
      checks++;
      failures++;
      $display("[TB] FAIL send_timeout kind=%0d got in_ready=%b required 1", kind, bus.in_ready);
    end else begin
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.in_kind  = NK_POP;
    bus.in_imm   = 32'hDEAD_BEEF;
  endtask

  task automatic num(input logic [31:0] v);
    send(NK_NUM, v, 8'd0);
  endtask

  task automatic addr(input logic [7:0] o);
    send(NK_ADDR, 32'd0, o);
  endtask

  task automatic op(input logic [3:0] k);
    send(k, 32'd0, 8'd0);
  endtask

  task automatic idle_random();
    int n;
    n = $urandom_range(0, 3);
    repeat (n) begin
      bus.in_valid = 1'b0;
      bus.in_kind  = 4'($urandom_range(0, 15));
      bus.in_imm   = $urandom;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.in_ready, bus.ret_valid, bus.err_valid, bus.busy, bus.err_code} !== 7'b1000_000) begin
      failures++;
      $display("[TB] FAIL reset_flags got=%b required=1000000",
               {bus.in_ready, bus.ret_valid, bus.err_valid, bus.busy, bus.err_code});
    end
    checks++;
    if (bus.ret_value !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_ret_value got=%0h required=0", bus.ret_value);
    end
  endtask

  task automatic test_arith();
    do_reset();
    num(32'd7); num(32'd5); op(NK_SUB); num(32'd3); op(NK_MUL); op(NK_RET);
    checks++;
    if ({bus.ret_valid, bus.in_ready, bus.err_valid} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL arith_flags got=%b required=100", {bus.ret_valid, bus.in_ready, bus.err_valid});
    end
    checks++;
    if (bus.ret_value !== 32'd6) begin
      failures++;
      $display("[TB] FAIL arith_ret_value got=%0d required=6", bus.ret_value);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.ret_valid, bus.in_ready} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL arith_halt_hold got=%b required=10", {bus.ret_valid, bus.in_ready});
    end
  endtask

  task automatic test_frame();
    do_reset();
    addr(8'd8); num(32'd42); op(NK_ASSIGN); op(NK_POP);
    addr(8'd8); op(NK_LOAD); num(32'd42); op(NK_EQ); op(NK_RET);
    checks++;
    if (bus.ret_value !== 32'd1 || bus.ret_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL frame_eq got=%0d/%b required=1/1", bus.ret_value, bus.ret_valid);
    end
    do_reset();
    addr(8'd248); num(32'd5); op(NK_ASSIGN); op(NK_POP);
    addr(8'd16); num(32'd9); op(NK_ASSIGN); op(NK_POP);
    addr(8'd248); op(NK_LOAD); addr(8'd16); op(NK_LOAD); op(NK_SUB); op(NK_RET);
    checks++;
    if (bus.ret_value !== 32'hFFFF_FFFC) begin
      failures++;
      $display("[TB] FAIL frame_slots got=%0h required=fffffffc", bus.ret_value);
    end
    do_reset();
    addr(8'd248); op(NK_LOAD); op(NK_RET);
    checks++;
    if (bus.ret_value !== 32'd0) begin
      failures++;
      $display("[TB] FAIL frame_reset_clear got=%0h required=0", bus.ret_value);
    end
  endtask

  task automatic test_alu();
    logic [3:0]  kinds [9];
    logic [31:0] opA [9];
    logic [31:0] opB [9];
    logic [31:0] want [9];
    kinds = '{NK_ADD, NK_SUB, NK_MUL, NK_MUL, NK_EQ, NK_NE, NK_GT, NK_GE, NK_GT};
    opA   = '{32'hFFFF_FFFF, 32'd3, 32'h0001_0000, 32'd7, 32'd5, 32'd5, 32'hFFFF_FFFF, 32'd4, 32'd2};
    opB   = '{32'd2, 32'd5, 32'h0001_0000, 32'hFFFF_FFFD, 32'd5, 32'd5, 32'd1, 32'd4, 32'hFFFF_FFFD};
    want  = '{32'd1, 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFEB, 32'd1, 32'd0, 32'd0, 32'd1, 32'd1};
    for (int i = 0; i < 9; i++) begin
      do_reset();
      num(opA[i]); num(opB[i]); op(kinds[i]); op(NK_RET);
      checks++;
      if (bus.ret_value !== want[i] || bus.ret_valid !== 1'b1) begin
        failures++;
        $display("[TB] FAIL alu_%0d kind=%0d got=%0h required=%0h", i, kinds[i], bus.ret_value, want[i]);
      end
    end
  endtask

  task automatic test_div();
`ifdef EXPR_EXEC_DIV_EN
    int cyc;
    do_reset();
    num(32'hFFFF_FFF9); num(32'd2); op(NK_DIV);
    checks++;
    if ({bus.busy, bus.in_ready} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL div_enter got=%b required=10", {bus.busy, bus.in_ready});
    end
    cyc = 1;
    while (bus.busy === 1'b1 && cyc < 100) begin
      @(posedge clk);
      #1;
      if (bus.busy === 1'b1) cyc++;
    end
    checks++;
    if (cyc !== 33 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL div_busy_cycles got=%0d ready=%b required=33 ready=1", cyc, bus.in_ready);
    end
    op(NK_RET);
    checks++;
    if (bus.ret_value !== 32'hFFFF_FFFD) begin
      failures++;
      $display("[TB] FAIL div_neg got=%0h required=fffffffd", bus.ret_value);
    end
    do_reset();
    num(32'h8000_0000); num(32'hFFFF_FFFF); op(NK_DIV); op(NK_RET);
    checks++;
    if (bus.ret_value !== 32'h8000_0000) begin
      failures++;
      $display("[TB] FAIL div_min_neg1 got=%0h required=80000000", bus.ret_value);
    end
    do_reset();
    num(32'd100); num(32'd7); op(NK_DIV);
    repeat (5) @(posedge clk);
    #1;
    do_reset();
    checks++;
    if ({bus.busy, bus.in_ready, bus.err_valid, bus.ret_valid} !== 4'b0100) begin
      failures++;
      $display("[TB] FAIL div_abort got=%b required=0100", {bus.busy, bus.in_ready, bus.err_valid, bus.ret_valid});
    end
    num(32'd100); num(32'd7); op(NK_DIV); op(NK_RET);
    checks++;
    if (bus.ret_value !== 32'd14) begin
      failures++;
      $display("[TB] FAIL div_after_abort got=%0d required=14", bus.ret_value);
    end
`else
    do_reset();
    num(32'hFFFF_FFF9); num(32'd2); op(NK_DIV);
    checks++;
    if ({bus.err_valid, bus.err_code, bus.busy, bus.in_ready} !== 6'b1_100_00) begin
      failures++;
      $display("[TB] FAIL div_disabled got=%b required=110000",
               {bus.err_valid, bus.err_code, bus.busy, bus.in_ready});
    end
`endif
  endtask

  task automatic test_div_zero();
    do_reset();
    num(32'd1); num(32'd0); op(NK_DIV);
    checks++;
    if ({bus.err_valid, bus.err_code, bus.in_ready, bus.ret_valid} !== {1'b1, DIV0_CODE, 2'b00}) begin
      failures++;
      $display("[TB] FAIL div_zero got=%b required=%b",
               {bus.err_valid, bus.err_code, bus.in_ready, bus.ret_valid}, {1'b1, DIV0_CODE, 2'b00});
    end
    do_reset();
    checks++;
    if ({bus.in_ready, bus.ret_valid, bus.err_valid, bus.busy, bus.err_code} !== 7'b1000_000
        || bus.ret_value !== 32'd0) begin
      failures++;
      $display("[TB] FAIL div_zero_reset got=%b required=1000000",
               {bus.in_ready, bus.ret_valid, bus.err_valid, bus.busy, bus.err_code});
    end
  endtask

  task automatic test_faults();
    do_reset();
    for (int i = 0; i < 16; i++) num(32'(i));
    checks++;
    if ({bus.err_valid, bus.in_ready} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL full_stack_ok got=%b required=01", {bus.err_valid, bus.in_ready});
    end
    num(32'd99);
    checks++;
    if ({bus.err_valid, bus.err_code, bus.in_ready} !== 5'b1_010_0) begin
      failures++;
      $display("[TB] FAIL overflow got=%b required=10100", {bus.err_valid, bus.err_code, bus.in_ready});
    end
    do_reset();
    op(NK_ADD);
    checks++;
    if ({bus.err_valid, bus.err_code} !== 4'b1_001) begin
      failures++;
      $display("[TB] FAIL underflow_add got=%b required=1001", {bus.err_valid, bus.err_code});
    end
    do_reset();
    op(NK_RET);
    checks++;
    if ({bus.err_valid, bus.err_code, bus.ret_valid} !== 5'b1_001_0) begin
      failures++;
      $display("[TB] FAIL underflow_ret got=%b required=10010", {bus.err_valid, bus.err_code, bus.ret_valid});
    end
    do_reset();
    addr(8'd12); op(NK_LOAD);
    checks++;
    if ({bus.err_valid, bus.err_code} !== 4'b1_100) begin
      failures++;
      $display("[TB] FAIL misaligned_load got=%b required=1100", {bus.err_valid, bus.err_code});
    end
    do_reset();
    num(32'd256); op(NK_LOAD);
    checks++;
    if ({bus.err_valid, bus.err_code} !== 4'b1_100) begin
      failures++;
      $display("[TB] FAIL range_load got=%b required=1100", {bus.err_valid, bus.err_code});
    end
    do_reset();
    addr(8'd4); num(32'd1); op(NK_ASSIGN);
    checks++;
    if ({bus.err_valid, bus.err_code} !== 4'b1_100) begin
      failures++;
      $display("[TB] FAIL misaligned_assign got=%b required=1100", {bus.err_valid, bus.err_code});
    end
    do_reset();
    num(32'd1); op(4'd14);
    checks++;
    if ({bus.err_valid, bus.err_code, bus.in_ready} !== 5'b1_100_0) begin
      failures++;
      $display("[TB] FAIL illegal_kind got=%b required=11000", {bus.err_valid, bus.err_code, bus.in_ready});
    end
  endtask

  task automatic test_random_valid();
    do_reset();
    idle_random(); num(32'd1);
    idle_random(); num(32'd2);
    idle_random(); op(NK_GT);
    idle_random(); op(NK_RET);
    checks++;
    if (bus.ret_value !== 32'd0 || bus.ret_valid !== 1'b1 || bus.err_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL random_gt got=%0h/%b/%b required=0/1/0", bus.ret_value, bus.ret_valid, bus.err_valid);
    end
    do_reset();
    idle_random(); num(32'd10);
    idle_random(); num(32'd3);
    idle_random(); op(NK_SUB);
    idle_random(); op(NK_RET);
    checks++;
    if (bus.ret_value !== 32'd7 || bus.ret_valid !== 1'b1 || bus.err_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL random_sub got=%0h/%b/%b required=7/1/0", bus.ret_value, bus.ret_valid, bus.err_valid);
    end
  endtask

  // Scenario sequence followed by the single summary line.
  initial begin
    bus.in_valid = 1'b0;
    bus.in_kind  = NK_POP;
    bus.in_imm   = '0;
    bus.in_off   = '0;
    test_reset();
    test_arith();
    test_frame();
    test_alu();
    test_div();
    test_div_zero();
    test_faults();
    test_random_valid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/expr_exec_ctrl.md
# expr_exec_ctrl

Sequencer for the stack-machine form of parsed statements. Consumes a postorder stream of expression nodes (number, local-variable address, load, assign, arithmetic, comparison, statement pop, return) over a valid/ready handshake. Executes each node against an internal evaluation stack and a local-variable register frame. Sits downstream of the parser/codegen and exposes the returned value and any execution fault.

## Interface
- `DATA_W`, 32: operand, stack and local-variable width.
- `STACK_DEPTH`, 16: evaluation stack entries.
- `NUM_LVARS`, 32: local slots. Each slot is 8 bytes; `OFF_W = $clog2(NUM_LVARS)+3`.
- `clk` in 1: clock, single domain.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: node present.
- `in_ready` out 1: node accepted when `in_valid && in_ready`.
- `in_kind` in 4: node opcode (see package).
- `in_imm` in DATA_W: immediate for NUM.
- `in_off` in OFF_W: byte offset for ADDR.
- `ret_valid` out 1: RET executed; held high in HALT.
- `ret_value` out DATA_W: returned value.
- `err_valid` out 1: fault occurred; held high in HALT.
- `err_code` out 3: 1 underflow, 2 overflow, 3 divide-by-zero, 4 illegal kind/offset.
- `busy` out 1: high in DIV_WAIT.

## Operation
- NUM: push `in_imm`.
- ADDR: push `in_off`.
- LOAD: pop address, push `frame[addr>>3]`.
- ASSIGN: pop value, pop address, write frame, push value.
- ADD/SUB/MUL: pop b, pop a, push a op b, mod 2^DATA_W (MUL keeps the low DATA_W bits).
- DIV: signed, truncates toward zero; `MIN/-1` yields MIN.
- EQ/NE/GT/GE: signed compare, push 1 or 0.
- POP: discard top.
- RET: pop into `ret_value`, go to HALT.
- Faults:
  - Underflow: pop with insufficient entries.
  - Overflow: push when full. ASSIGN and binary ops net-shrink the stack, so they never overflow.
  - Divide-by-zero: divisor 0.
  - Illegal: undefined kind, or an address that is not a multiple of 8 or is ≥ NUM_LVARS*8.
  - On any fault: set `err_code`, go to HALT. The stack and frame are left unmodified by the faulting node.
- FSM:
  - RUN → DIV_WAIT on an accepted DIV with nonzero divisor.
  - DIV_WAIT → RUN on divider done (quotient pushed).
  - RUN → HALT on RET or fault. HALT is left only by `rst`.
- Reset values:
  - State RUN, stack pointer 0, all frame slots 0.
  - `ret_valid`=0, `ret_value`=0, `err_valid`=0, `err_code`=0, `busy`=0.
  - `in_ready`=1 from the first post-reset cycle.

## Timing
- All non-DIV nodes: accepted and retired in 1 cycle, throughput one node/cycle. The result is visible to the next node's operands via the registered stack, with no bubble.
- DIV: `in_ready` drops the cycle after acceptance. It stays low for DATA_W+1 cycles, then the quotient is on top of the stack and `in_ready` rises.
- `in_ready` = (state==RUN). It is combinationally independent of `in_valid`.
- RET and fault: `ret_valid`/`err_valid` rise the cycle after acceptance; `in_ready` is 0 from that cycle.
- `rst` asserted mid-DIV aborts the divider and clears everything the next edge.
- A RET that underflows reports error 1 with `ret_valid`=0.

## Configuration
- `EXPR_EXEC_DIV_EN` defined: the divider sub-module is instantiated and DIV behaves as above.
- Undefined: no divider and no DIV_WAIT state. DIV raises err 4 in 1 cycle, and `busy` is tied 0.

## Structure
- Package `expr_exec_pkg` holds:
  - `node_kind_e`: NUM=0, ADDR=1, LOAD=2, ASSIGN=3, ADD=4, SUB=5, MUL=6, DIV=7, EQ=8, NE=9, GT=10, GE=11, POP=12, RET=13.
  - `err_code_e`.
  - `state_e`.
- Sub-module `expr_exec_div`: iterative signed restoring divider, one bit/cycle, start/done handshake, takes DATA_W+1 cycles.
- Stack and frame are flop arrays inside the top.

## Test plan
- Stream NUM 7, NUM 5, SUB, NUM 3, MUL, RET → `ret_value`=6, `ret_valid`=1 one cycle after RET, `in_ready`=0 after.
- ADDR 8, NUM 42, ASSIGN, POP, ADDR 8, LOAD, NUM 42, EQ, RET → `ret_value`=1, and frame slot 1 reads 42.
- NUM -7, NUM 2, DIV, RET with `EXPR_EXEC_DIV_EN` → `busy` high 33 cycles and `ret_value`=-3. Without the macro → `err_code`=4.
- NUM 1, NUM 0, DIV → `err_code`=3 and `in_ready`=0. Then pulse `rst` → all outputs 0 and `in_ready`=1.
- 16 NUM pushes then a 17th → `err_code`=2. Fresh run with a lone ADD → `err_code`=1. ADDR 12 then LOAD → `err_code`=4.
- `in_valid` toggled randomly over 1 NUM, 2 NUM, GT, RET → `ret_value`=0, and no node is lost or duplicated.
